// File: rtl/out_word_serialiser_if.sv
// out_word_serialiser_if
//   Bundles the word-in pair coming from the AHB output-register slave and the
//   3-wire serial link plus status leaving the serialiser.
//   DataIn[31:0]  word to transmit (slave DataOut)
//   DataValid     DataIn is displayable (slave DataValid)
//   SCLK          serial clock, idle low, sampled externally on rising edge
//   SDATA         serial data, changes only while SCLK is low
//   SLOAD         latch strobe to the external chain
//   Ack           transfer-complete level (to slave Buttons)
//   Busy          serialiser not idle
//   Modport slave is the serialiser's view; master is the driving/observing side.
interface out_word_serialiser_if;
  logic [31:0] DataIn;
  logic        DataValid;
  logic        SCLK;
  logic        SDATA;
  logic        SLOAD;
  logic        Ack;
  logic        Busy;

  modport master (
    output DataIn,
    output DataValid,
    input  SCLK,
    input  SDATA,
    input  SLOAD,
    input  Ack,
    input  Busy
  );

  modport slave (
    input  DataIn,
    input  DataValid,
    output SCLK,
    output SDATA,
    output SLOAD,
    output Ack,
    output Busy
  );
endinterface

// File: rtl/out_word_serialiser.sv
// out_word_serialiser
//   Shifts each new valid 32-bit word from the AHB output slave out on a
//   SCLK/SDATA/SLOAD link, then raises Ack for ACK_CYCLES cycles so software
//   sees OutFlag once the word has left the chip. One word can be parked while
//   a transfer is in flight; later arrivals overwrite it.
// Parameters
//   CLK_DIV     HCLK cycles per SCLK half-period (1..255)
//   ACK_CYCLES  HCLK cycles Ack is held high (1..2^21-1)
//   LSB_FIRST   0: bit 31 first, 1: bit 0 first
// Ports
//   HCLK        system clock, rising edge
//   HRESET      asynchronous active-high reset
//   link        out_word_serialiser_if.slave (DataIn/DataValid in, serial + status out)
module out_word_serialiser #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned ACK_CYCLES = 4,
  parameter bit          LSB_FIRST  = 1'b0
) (
  input logic                  HCLK,
  input logic                  HRESET,
  out_word_serialiser_if.slave link
);

  typedef enum logic [1:0] {StIdle, StShift, StLatch, StAck} state_e;

  localparam logic [7:0]  DivLast = 8'(CLK_DIV - 1);
  localparam logic [20:0] AckLast = 21'(ACK_CYCLES - 1);

  state_e      state_q;
  logic [31:0] shift_q;
  logic [31:0] pend_word_q;
  logic [31:0] last_word_q;
  logic        pend_flag_q;
  logic        dv_q;
  logic [5:0]  bit_cnt_q;
  logic [7:0]  div_cnt_q;
  logic [20:0] ack_cnt_q;
  logic        sclk_q;
  logic        sdata_q;
  logic        sload_q;
  logic        ack_q;
  logic        busy_q;

  logic        new_word;
  logic        start;
  logic [31:0] start_word;
  logic        start_bit;
  logic [31:0] shift_next;
  logic        next_bit;

  always_comb begin
    new_word   = link.DataValid && (!dv_q || (link.DataIn != last_word_q));
    start      = (state_q == StIdle) && (pend_flag_q || new_word);
    // A parked word is older than anything arriving now, so it goes first.
    start_word = pend_flag_q ? pend_word_q : link.DataIn;
    start_bit  = LSB_FIRST ? start_word[0] : start_word[31];
    shift_next = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);
    next_bit   = LSB_FIRST ? shift_q[1] : shift_q[30];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      pend_word_q <= '0;
      last_word_q <= '0;
      pend_flag_q <= 1'b0;
      dv_q        <= 1'b0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      ack_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      sload_q     <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      dv_q        <= link.DataValid;
      last_word_q <= link.DataIn;

      // Park new words while busy, or while the parked word is being launched
      // this cycle; otherwise launching clears the flag.
      if (new_word && ((state_q != StIdle) || pend_flag_q)) begin
        pend_word_q <= link.DataIn;
        pend_flag_q <= 1'b1;
      end else if (start) begin
        pend_flag_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StShift;
            shift_q   <= start_word;
            sdata_q   <= start_bit;
            sclk_q    <= 1'b0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end

        StShift: begin
          if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q    <= 1'b0;
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'd31) begin
                // Last high phase done: SDATA keeps the final bit through LATCH.
                state_q <= StLatch;
                sload_q <= 1'b1;
              end else begin
                shift_q <= shift_next;
                sdata_q <= next_bit;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end

        StLatch: begin
          if (div_cnt_q == DivLast) begin
            state_q   <= StAck;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sload_q   <= 1'b0;
            sdata_q   <= 1'b0;
            ack_q     <= 1'b1;
            ack_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
          end
        end

        StAck: begin
          if (ack_cnt_q == AckLast) begin
            state_q   <= StIdle;
            ack_cnt_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            ack_cnt_q <= ack_cnt_q + 21'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign link.SCLK  = sclk_q;
  assign link.SDATA = sdata_q;
  assign link.SLOAD = sload_q;
  assign link.Ack   = ack_q;
  assign link.Busy  = busy_q;

endmodule
